// File: rtl/rpn_stack_unit_if.sv
// Command/status bundle between a front-end (master) and the RPN stack unit (slave).
// The cnt width is derived here so both sides agree on it.
interface rpn_stack_unit_if #(
  parameter int W     = 16,
  parameter int DEPTH = 1024
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    cmd;
  logic [W-1:0]  d;
  logic          err_clr;
  logic [W-1:0]  top;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;
  logic          ovf;
  logic          unf;

  modport master (
    output in_valid, cmd, d, err_clr,
    input  in_ready, top, cnt, busy, done, ovf, unf
  );

  modport slave (
    input  in_valid, cmd, d, err_clr,
    output in_ready, top, cnt, busy, done, ovf, unf
  );
endinterface

// File: rtl/rpn_stack_unit.sv
// RPN stack calculator: top-of-stack in a register, the rest in async-read memory,
// with an iterative shift-add multiplier that blocks new commands while it runs.
module rpn_stack_unit #(
  parameter int W     = 16,
  parameter int DEPTH = 1024
) (
  input  logic            step,
  input  logic            nrst,
  rpn_stack_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(W);

  localparam logic [2:0] C_PUSH = 3'b001;
  localparam logic [2:0] C_ADD  = 3'b010;
  localparam logic [2:0] C_SUB  = 3'b011;
  localparam logic [2:0] C_MUL  = 3'b100;
  localparam logic [2:0] C_NEG  = 3'b101;
  localparam logic [2:0] C_DUP  = 3'b110;
  localparam logic [2:0] C_SWAP = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Element i of the stack below T lives at mem[i]; S is mem[cnt-2].
  logic [W-1:0]  mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  logic [AW-1:0] cnt_lo;
  logic          accept, has1, has2, full;
  logic          ovf_set, unf_set;
  logic [W-1:0]  acc_step;

  assign cnt_lo   = cnt_q[AW-1:0];
  assign accept   = bus.in_valid && (state_q == S_IDLE);
  assign has1     = (cnt_q != '0);
  assign has2     = (cnt_q > CW'(1));
  assign full     = (cnt_q == CW'(DEPTH));
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // While multiplying, both operands are popped, so the visible top is mem[cnt-1].
  assign rd_addr = (state_q == S_MUL) ? cnt_lo - AW'(1) : cnt_lo - AW'(2);
  assign rd_data = mem[rd_addr];

  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_lo - AW'(1);
    mem_wdata = top_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    if (state_q == S_MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      bit_d    = bit_q + BW'(1);
      if (bit_q == BW'(W - 1)) begin
        top_d   = acc_step;
        cnt_d   = cnt_q + CW'(1);
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end else if (accept) begin
      done_d = 1'b1;
      case (bus.cmd)
        C_PUSH: begin
          if (full) ovf_set = 1'b1;
          else begin
            top_d  = bus.d;
            cnt_d  = cnt_q + CW'(1);
            mem_we = has1;
          end
        end
        C_ADD: begin
          if (!has2) unf_set = 1'b1;
          else begin
            top_d = rd_data + top_q;
            cnt_d = cnt_q - CW'(1);
          end
        end
        C_SUB: begin
          if (!has2) unf_set = 1'b1;
          else begin
            top_d = rd_data - top_q;
            cnt_d = cnt_q - CW'(1);
          end
        end
        C_MUL: begin
          if (!has2) unf_set = 1'b1;
          else begin
            done_d   = 1'b0;
            state_d  = S_MUL;
            cnt_d    = cnt_q - CW'(2);
            mcand_d  = top_q;
            mplier_d = rd_data;
            acc_d    = '0;
            bit_d    = '0;
          end
        end
        C_NEG: begin
          if (!has1) unf_set = 1'b1;
          else top_d = -top_q;
        end
        C_DUP: begin
          if (!has1) unf_set = 1'b1;
          else if (full) ovf_set = 1'b1;
          else begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        C_SWAP: begin
          if (!has2) unf_set = 1'b1;
          else begin
            mem_we    = 1'b1;
            mem_waddr = cnt_lo - AW'(2);
            top_d     = rd_data;
          end
        end
        default: ;
      endcase
    end

    // A new error wins over a simultaneous clear.
    ovf_d = (ovf_q & ~bus.err_clr) | ovf_set;
    unf_d = (unf_q & ~bus.err_clr) | unf_set;
  end

  always_ff @(posedge step or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      top_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      top_q    <= top_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge step) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_MUL);
  assign bus.top      = !has1 ? '0 : ((state_q == S_MUL) ? rd_data : top_q);
  assign bus.cnt      = cnt_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
endmodule

// File: tb/tb_rpn_stack_unit.sv
// Directed bench for rpn_stack_unit (W=16, DEPTH=4): one task per scenario,
// each comparing the packed status word {busy,done,ovf,unf,cnt,top} against hand-computed values.
module tb_rpn_stack_unit;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] PUSH = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] MUL  = 3'b100;
  localparam logic [2:0] NEG  = 3'b101;
  localparam logic [2:0] DUP  = 3'b110;
  localparam logic [2:0] SWAP = 3'b111;

  logic step;
  logic nrst;
  int   n_checks;
  int   n_fail;

  rpn_stack_unit_if #(.W(W), .DEPTH(DEPTH)) bus ();

  rpn_stack_unit #(.W(W), .DEPTH(DEPTH)) dut (
    .step (step),
    .nrst (nrst),
    .bus  (bus)
  );

  logic [22:0] st;
  logic [22:0] want;
  assign st = {bus.busy, bus.done, bus.ovf, bus.unf, bus.cnt, bus.top};

  initial step = 1'b0;
  always #5 step = ~step;

  function automatic logic [22:0] pk(input bit b, input bit dn, input bit o, input bit u,
                                     input int c, input logic [15:0] t);
    return {b, dn, o, u, 3'(c), t};
  endfunction

  task automatic issue(input logic [2:0] c, input logic [15:0] v);
    @(negedge step);
    bus.in_valid = 1'b1;
    bus.cmd      = c;
    bus.d        = v;
    @(posedge step);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    nrst         = 1'b0;
    bus.in_valid = 1'b0;
    bus.err_clr  = 1'b0;
    bus.cmd      = NOP;
    bus.d        = '0;
    repeat (2) @(posedge step);
    @(negedge step);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    want = pk(0, 0, 0, 0, 0, 16'h0000);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL reset_state: got %h want %h", st, want); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    $display("reset: status=%h", st);
  endtask

  task automatic test_add_sub_neg();
    do_reset();
    issue(PUSH, 16'd3);
    issue(PUSH, 16'd4);
    issue(ADD, 16'd0);
    want = pk(0, 1, 0, 0, 1, 16'd7);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL add_3_4: got %h want %h", st, want); end
    $display("ADD 3+4: status=%h", st);
    @(posedge step); #1;
    want = pk(0, 0, 0, 0, 1, 16'd7);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL done_single_pulse: got %h want %h", st, want); end

    do_reset();
    issue(PUSH, 16'd5);
    issue(PUSH, 16'd2);
    issue(SUB, 16'd0);
    issue(NEG, 16'd0);
    want = pk(0, 1, 0, 0, 1, 16'hFFFD);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL sub_neg: got %h want %h", st, want); end
    $display("5-2 NEG: status=%h", st);
    issue(PUSH, 16'h7FFF);
    issue(PUSH, 16'h0001);
    issue(ADD, 16'd0);
    want = pk(0, 1, 0, 0, 2, 16'h8000);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL add_wrap: got %h want %h", st, want); end
    $display("7FFF+1: status=%h", st);
    issue(NEG, 16'd0);
    want = pk(0, 1, 0, 0, 2, 16'h8000);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL neg_min: got %h want %h", st, want); end
    $display("NEG 8000: status=%h", st);
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(PUSH, 16'd10);
    want = pk(0, 1, 0, 0, 1, 16'd10);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL b2b_push10: got %h want %h", st, want); end
    issue(PUSH, 16'd20);
    want = pk(0, 1, 0, 0, 2, 16'd20);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL b2b_push20: got %h want %h", st, want); end
    issue(SUB, 16'd0);
    want = pk(0, 1, 0, 0, 1, 16'hFFF6);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL b2b_sub: got %h want %h", st, want); end
    issue(DUP, 16'd0);
    want = pk(0, 1, 0, 0, 2, 16'hFFF6);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL b2b_dup: got %h want %h", st, want); end
    issue(ADD, 16'd0);
    want = pk(0, 1, 0, 0, 1, 16'hFFEC);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL b2b_add: got %h want %h", st, want); end
    $display("back-to-back: status=%h", st);
  endtask

  task automatic test_mul();
    do_reset();
    issue(PUSH, 16'd100);
    issue(PUSH, 16'hFFF9);
    issue(PUSH, 16'd6);
    @(negedge step);
    bus.in_valid = 1'b1;
    bus.cmd      = MUL;
    @(posedge step); #1;
    // Hold a PUSH pending through the whole multiply; it must wait.
    bus.cmd = PUSH;
    bus.d   = 16'd55;
    want = pk(1, 0, 0, 0, 1, 16'd100);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL mul_accept: got %h want %h", st, want); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready_low: got %b want 0", bus.in_ready); end
    for (int k = 1; k < W; k++) begin
      @(posedge step); #1;
      n_checks++; if (st !== want) begin n_fail++; $display("FAIL mul_busy_cycle%0d: got %h want %h", k, st, want); end
    end
    @(posedge step); #1;
    want = pk(0, 1, 0, 0, 2, 16'hFFD6);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL mul_result: got %h want %h", st, want); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready_back: got %b want 1", bus.in_ready); end
    $display("MUL -7*6: status=%h", st);
    @(posedge step); #1;
    bus.in_valid = 1'b0;
    want = pk(0, 1, 0, 0, 3, 16'd55);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL push_after_mul: got %h want %h", st, want); end
    $display("PUSH held during MUL: status=%h", st);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) issue(PUSH, 16'(i));
    issue(PUSH, 16'd9);
    want = pk(0, 1, 1, 0, 4, 16'd4);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL push_full: got %h want %h", st, want); end
    $display("PUSH when full: status=%h", st);
    bus.err_clr = 1'b1;
    issue(NOP, 16'd0);
    bus.err_clr = 1'b0;
    want = pk(0, 1, 0, 0, 4, 16'd4);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", st, want); end
    issue(DUP, 16'd0);
    want = pk(0, 1, 1, 0, 4, 16'd4);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL dup_full: got %h want %h", st, want); end
    bus.err_clr = 1'b1;
    issue(PUSH, 16'd9);
    bus.err_clr = 1'b0;
    want = pk(0, 1, 1, 0, 4, 16'd4);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL clr_vs_new_ovf: got %h want %h", st, want); end
    $display("err_clr with new ovf: status=%h", st);
  endtask

  task automatic test_underflow();
    do_reset();
    issue(PUSH, 16'd8);
    issue(ADD, 16'd0);
    want = pk(0, 1, 0, 1, 1, 16'd8);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL add_unf: got %h want %h", st, want); end
    $display("ADD cnt=1: status=%h", st);
    @(negedge step);
    bus.err_clr = 1'b1;
    @(posedge step); #1;
    bus.err_clr = 1'b0;
    want = pk(0, 0, 0, 0, 1, 16'd8);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL unf_clear: got %h want %h", st, want); end
    issue(SWAP, 16'd0);
    want = pk(0, 1, 0, 1, 1, 16'd8);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL swap_unf: got %h want %h", st, want); end
    bus.err_clr = 1'b1;
    issue(NOP, 16'd0);
    bus.err_clr = 1'b0;
    issue(MUL, 16'd0);
    want = pk(0, 1, 0, 1, 1, 16'd8);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL mul_unf: got %h want %h", st, want); end
    $display("MUL cnt=1: status=%h", st);
  endtask

  task automatic test_swap_dup();
    do_reset();
    issue(PUSH, 16'd1);
    issue(PUSH, 16'd2);
    issue(SWAP, 16'd0);
    want = pk(0, 1, 0, 0, 2, 16'd1);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL swap: got %h want %h", st, want); end
    issue(DUP, 16'd0);
    want = pk(0, 1, 0, 0, 3, 16'd1);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL dup: got %h want %h", st, want); end
    issue(ADD, 16'd0);
    want = pk(0, 1, 0, 0, 2, 16'd2);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL dup_s_check: got %h want %h", st, want); end
    issue(SUB, 16'd0);
    want = pk(0, 1, 0, 0, 1, 16'd0);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL swap_below_check: got %h want %h", st, want); end
    $display("SWAP/DUP stack walk: status=%h", st);
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    issue(PUSH, 16'd3);
    issue(PUSH, 16'd5);
    issue(MUL, 16'd0);
    repeat (5) @(posedge step);
    @(negedge step);
    nrst = 1'b0;
    #1;
    want = pk(0, 0, 0, 0, 0, 16'd0);
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL reset_mid_mul: got %h want %h", st, want); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_mul_ready: got %b want 1", bus.in_ready); end
    @(negedge step);
    nrst = 1'b1;
    repeat (W + 2) @(posedge step);
    #1;
    n_checks++; if (st !== want) begin n_fail++; $display("FAIL no_result_after_abort: got %h want %h", st, want); end
    $display("reset mid-MUL: status=%h", st);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add_sub_neg();
    test_back_to_back();
    test_mul();
    test_overflow();
    test_underflow();
    test_swap_dup();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
